// File: rtl/spi_txn_queue.sv
// spi_txn_queue: queues SPI transactions, issues them to spi_master one at a time and buffers masked responses
module spi_txn_queue #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int SLAVE_ADDRS_LEN = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [31:0]                      cmd_data,
  input  logic [SLAVE_ADDRS_LEN-1:0]       cmd_addr,
  input  logic [1:0]                       cmd_len,
  input  logic                             cmd_nores,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_data,
  output logic [SLAVE_ADDRS_LEN-1:0]       rsp_addr,
  output logic                             spi_start,
  output logic [31:0]                      spi_tx_data,
  output logic [SLAVE_ADDRS_LEN-1:0]       spi_chip_addr,
  output logic [1:0]                       spi_length,
  input  logic                             spi_busy,
  input  logic [31:0]                      spi_rx_data,
  output logic [$clog2(CMD_DEPTH):0]       cmd_count,
  output logic                             idle
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RSP_DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;
  state_t state;
  logic [31:0]                cq_data  [CMD_DEPTH];
  logic [SLAVE_ADDRS_LEN-1:0] cq_addr  [CMD_DEPTH];
  logic [1:0]                 cq_len   [CMD_DEPTH];
  logic                       cq_nores [CMD_DEPTH];
  logic [31:0]                rq_data  [RSP_DEPTH];
  logic [SLAVE_ADDRS_LEN-1:0] rq_addr  [RSP_DEPTH];
  logic [CW-1:0] cwp, crp;
  logic [RW-1:0] rwp, rrp;
  logic [RW:0]   rsp_count;
  logic [1:0]    tmr;
  logic cmd_push, cmd_pop, rsp_push, rsp_pop, launch, retry, go;
  logic [31:0] rx_masked;
  assign cmd_ready = cmd_count < (CW+1)'(CMD_DEPTH);
  assign cmd_push  = cmd_valid & cmd_ready;
  assign cmd_pop   = state == CAPTURE;
  assign rsp_push  = cmd_pop & ~cq_nores[crp];
  assign rsp_valid = rsp_count != '0;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_data  = rq_data[rrp];
  assign rsp_addr  = rq_addr[rrp];
  assign idle      = state == IDLE && cmd_count == '0;
  // a response slot is reserved before issuing so CAPTURE can always push
  assign launch    = state == IDLE && cmd_count != '0 && (cq_nores[crp] || rsp_count < (RW+1)'(RSP_DEPTH));
  assign retry     = state == WAIT_BUSY && !spi_busy && tmr == 2'd3;
  assign go        = launch | retry;
  assign rx_masked = spi_length == 2'd0 ? {24'd0, spi_rx_data[7:0]} :
                     spi_length == 2'd1 ? {16'd0, spi_rx_data[15:0]} :
                     spi_length == 2'd2 ? {8'd0, spi_rx_data[23:0]} : spi_rx_data;
  // FIFO storage, written without reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_data[cwp]  <= cmd_data;
      cq_addr[cwp]  <= cmd_addr;
      cq_len[cwp]   <= cmd_len;
      cq_nores[cwp] <= cmd_nores;
    end
    if (rsp_push) begin
      rq_data[rwp] <= rx_masked;
      rq_addr[rwp] <= spi_chip_addr;
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cwp       <= '0;
      crp       <= '0;
      cmd_count <= '0;
      rwp       <= '0;
      rrp       <= '0;
      rsp_count <= '0;
    end else begin
      if (cmd_push) cwp <= cwp + CW'(1);
      if (cmd_pop) crp <= crp + CW'(1);
      cmd_count <= cmd_count + (CW+1)'(cmd_push) - (CW+1)'(cmd_pop);
      if (rsp_push) rwp <= rwp + RW'(1);
      if (rsp_pop) rrp <= rrp + RW'(1);
      rsp_count <= rsp_count + (RW+1)'(rsp_push) - (RW+1)'(rsp_pop);
    end
  end
  // sequencer: issue head, wait for busy (restart after 4 idle cycles), wait for done, capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      spi_start     <= 1'b0;
      spi_tx_data   <= '0;
      spi_chip_addr <= '0;
      spi_length    <= '0;
      tmr           <= '0;
    end else begin
      spi_start <= go;
      if (go) begin
        spi_tx_data   <= cq_data[crp];
        spi_chip_addr <= cq_addr[crp];
        spi_length    <= cq_len[crp];
      end
      case (state)
        IDLE:      if (launch) state <= ISSUE;
        ISSUE: begin
          state <= WAIT_BUSY;
          tmr   <= '0;
        end
        WAIT_BUSY: if (spi_busy) state <= WAIT_DONE;
                   else if (retry) state <= ISSUE;
                   else tmr <= tmr + 2'd1;
        WAIT_DONE: if (!spi_busy) state <= CAPTURE;
        CAPTURE:   state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_queue.sv
// tb_spi_txn_queue: directed and random checks of spi_txn_queue against a queue-based model
module tb_spi_txn_queue;
  localparam int A = 3;
  typedef struct packed {logic [31:0] d; logic [A-1:0] a; logic [1:0] l; logic n;} cmd_t;
  typedef struct packed {logic [31:0] d; logic [A-1:0] a;} rsp_t;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_nores = 0, rsp_ready = 0;
  logic [31:0] cmd_data = 0;
  logic [A-1:0] cmd_addr = 0;
  logic [1:0] cmd_len = 0;
  logic cmd_ready, rsp_valid, spi_start, spi_busy, idle;
  logic [31:0] rsp_data, spi_tx_data, spi_rx_data;
  logic [A-1:0] rsp_addr, spi_chip_addr;
  logic [1:0] spi_length;
  logic [2:0] cmd_count;
  cmd_t mcmd[$];
  rsp_t mrsp[$];
  int n_chk = 0, n_fail = 0, n_start = 0;
  bit slv_en = 1, fix_rx = 0;
  logic [31:0] rx_fix = 0, rx_cur = 0;
  int blen_min = 2, blen_max = 6, ph = 0, rem = 0, dly = 0, d = 0;
  rsp_t r_tmp;

  always #5 clk = ~clk;

  spi_txn_queue #(.CMD_DEPTH(4), .RSP_DEPTH(4), .SLAVE_ADDRS_LEN(A)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_nores(cmd_nores), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .spi_start(spi_start),
    .spi_tx_data(spi_tx_data), .spi_chip_addr(spi_chip_addr), .spi_length(spi_length),
    .spi_busy(spi_busy), .spi_rx_data(spi_rx_data), .cmd_count(cmd_count), .idle(idle));

  function automatic logic [31:0] mask(logic [31:0] v, logic [1:0] l);
    logic [63:0] m;
    m = (64'd1 << (8 * (int'(l) + 1))) - 64'd1;
    return v & m[31:0];
  endfunction

  function automatic cmd_t mk(logic [31:0] dd, logic [A-1:0] a, logic [1:0] l, logic n);
    cmd_t c;
    c.d = dd; c.a = a; c.l = l; c.n = n;
    return c;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // spi_master stand-in: busy rises 0..2 cycles after start, rx updates one cycle before busy falls
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_busy <= 1'b0;
      spi_rx_data <= '0;
      ph <= 0;
    end else if (ph == 0) begin
      if (spi_start && slv_en) begin
        n_start++;
        chk("issue_model_nonempty", 32'(mcmd.size() != 0), 1);
        if (mcmd.size() != 0) begin
          chk("issue_tx_data", spi_tx_data, mcmd[0].d);
          chk("issue_addr", 32'(spi_chip_addr), 32'(mcmd[0].a));
          chk("issue_len", 32'(spi_length), 32'(mcmd[0].l));
        end
        rx_cur <= fix_rx ? rx_fix : $urandom;
        rem <= $urandom_range(blen_max, blen_min);
        d = $urandom_range(2, 0);
        if (d == 0) begin
          spi_busy <= 1'b1;
          ph <= 2;
        end else begin
          dly <= d;
          ph <= 1;
        end
      end
    end else if (ph == 1) begin
      if (dly == 1) begin
        spi_busy <= 1'b1;
        ph <= 2;
      end
      dly <= dly - 1;
    end else begin
      if (rem == 2) spi_rx_data <= rx_cur;
      if (rem == 1) begin
        spi_busy <= 1'b0;
        ph <= 0;
        if (mcmd.size() != 0) begin
          if (!mcmd[0].n) begin
            r_tmp.d = mask(rx_cur, mcmd[0].l);
            r_tmp.a = mcmd[0].a;
            mrsp.push_back(r_tmp);
          end
          void'(mcmd.pop_front());
        end
      end
      rem <= rem - 1;
    end
  end

  task automatic push(input cmd_t c, input int budget, output bit ok);
    ok = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_data = c.d; cmd_addr = c.a; cmd_len = c.l; cmd_nores = c.n;
    for (int i = 0; i < budget; i++) begin
      if (cmd_ready) begin
        mcmd.push_back(c);
        ok = 1;
      end else chk("refused_full_count", 32'(cmd_count), 4);
      @(posedge clk);
      #1;
      if (ok) break;
      @(negedge clk);
    end
    cmd_valid = 0;
    chk("push_accepted", 32'(ok), 1);
  endtask

  task automatic chk_head();
    chk("rsp_model_nonempty", 32'(mrsp.size() != 0), 1);
    if (mrsp.size() != 0) begin
      chk("rsp_data", rsp_data, mrsp[0].d);
      chk("rsp_addr", 32'(rsp_addr), 32'(mrsp[0].a));
    end
  endtask

  task automatic pop_one(input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk("pop_avail", 32'(got), 1);
    if (got) begin
      chk_head();
      rsp_ready = 1;
      @(posedge clk);
      #1;
      rsp_ready = 0;
      if (mrsp.size() != 0) void'(mrsp.pop_front());
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok, cv, rr, done;
    int s0;
    int pc[$];
    #2 rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_spi_start", 32'(spi_start), 0);
    chk("rst_cmd_count", 32'(cmd_count), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_tx_data", spi_tx_data, 0);
    chk("rst_chip_addr", 32'(spi_chip_addr), 0);
    chk("rst_length", 32'(spi_length), 0);
    rst = 1;
    // single 8-bit transaction with a fixed slave reply
    fix_rx = 1; rx_fix = 32'hFFFFFF3C; s0 = n_start;
    push(mk(32'h000000A5, 3'd2, 2'd0, 1'b0), 10, ok);
    wait_idle(100);
    chk("t1_starts", 32'(n_start - s0), 1);
    chk("t1_chip_addr", 32'(spi_chip_addr), 2);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_data_const", rsp_data, 32'h0000003C);
    chk("t1_rsp_addr_const", 32'(rsp_addr), 2);
    pop_one(5);
    fix_rx = 0;
    // back-to-back with slow transactions: FIFO fills, fifth push waits for a CAPTURE
    blen_min = 20; blen_max = 20;
    for (int i = 0; i < 4; i++) begin
      push(mk(32'h11111111 * (i + 1), 3'(i), 2'd3, 1'b0), 1, ok);
      chk("t2_ready_after_push", 32'(cmd_ready), 32'(i < 3));
    end
    push(mk(32'h55555555, 3'd4, 2'd3, 1'b0), 200, ok);
    for (int i = 0; i < 5; i++) pop_one(300);
    blen_min = 2; blen_max = 6;
    wait_idle(100);
    // response backpressure: only four transactions may issue
    s0 = n_start;
    for (int i = 0; i < 6; i++) push(mk($urandom, 3'($urandom), 2'($urandom), 1'b0), 200, ok);
    repeat (80) @(negedge clk);
    chk("t3_issued4", 32'(n_start - s0), 4);
    chk("t3_start_low", 32'(spi_start), 0);
    chk("t3_cmd_count", 32'(cmd_count), 2);
    chk("t3_not_idle", 32'(idle), 0);
    pop_one(5);
    repeat (40) @(negedge clk);
    chk("t3_issued5", 32'(n_start - s0), 5);
    pop_one(5);
    repeat (40) @(negedge clk);
    chk("t3_issued6", 32'(n_start - s0), 6);
    chk("t3_cmd_empty", 32'(cmd_count), 0);
    // write-only command proceeds while the response FIFO is full
    s0 = n_start;
    push(mk($urandom, 3'd5, 2'd1, 1'b1), 10, ok);
    wait_idle(100);
    chk("t4_issued", 32'(n_start - s0), 1);
    for (int i = 0; i < 4; i++) pop_one(5);
    @(negedge clk);
    chk("t4_rsp_empty", 32'(rsp_valid), 0);
    // busy never rises: start repeats every 5 cycles
    slv_en = 0;
    push(mk($urandom, 3'd6, 2'd2, 1'b0), 10, ok);
    for (int c = 0; c < 40 && pc.size() < 4; c++) begin
      @(negedge clk);
      if (spi_start) pc.push_back(c);
    end
    chk("t5_pulses", 32'(pc.size()), 4);
    for (int i = 1; i < pc.size(); i++) chk("t5_period", 32'(pc[i] - pc[i-1]), 5);
    chk("t5_not_idle", 32'(idle), 0);
    s0 = n_start;
    slv_en = 1;
    wait_idle(100);
    chk("t5_one_txn", 32'(n_start - s0), 1);
    pop_one(5);
    @(negedge clk);
    chk("t5_single_rsp", 32'(rsp_valid), 0);
    // asynchronous reset during a long transaction with two queued
    blen_min = 30; blen_max = 30;
    for (int i = 0; i < 3; i++) push(mk($urandom, 3'(i), 2'd3, 1'b0), 10, ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = spi_busy;
    end
    chk("t6_busy_seen", 32'(ok), 1);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("t6_start", 32'(spi_start), 0);
    chk("t6_cmd_count", 32'(cmd_count), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_idle", 32'(idle), 1);
    mcmd.delete(); mrsp.delete();
    blen_min = 2; blen_max = 6;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    chk("t6_no_rsp", 32'(rsp_valid), 0);
    chk("t6_still_idle", 32'(idle), 1);
    // random traffic with random response backpressure
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rr = 1'($urandom_range(1, 0));
      if (rsp_valid && rr) begin
        chk_head();
        if (mrsp.size() != 0) void'(mrsp.pop_front());
      end
      rsp_ready = rr;
      cv = $urandom_range(2, 0) == 0;
      cmd_data = $urandom; cmd_addr = 3'($urandom); cmd_len = 2'($urandom); cmd_nores = $urandom_range(3, 0) == 0;
      if (cv && cmd_ready) mcmd.push_back(mk(cmd_data, cmd_addr, cmd_len, cmd_nores));
      cmd_valid = cv;
    end
    @(negedge clk);
    cmd_valid = 0; rsp_ready = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk_head();
        if (mrsp.size() != 0) void'(mrsp.pop_front());
        rsp_ready = 1;
      end else rsp_ready = 0;
      done = idle && !rsp_valid && mcmd.size() == 0;
    end
    rsp_ready = 0;
    chk("rand_drained", 32'(done), 1);
    chk("rand_model_empty", 32'(mrsp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_txn_queue.md
Name: spi_txn_queue

Overview:
- Command/response sequencer that sits directly upstream of spi_master and drives its start_trans, tx_data, chipADDRS and transaction_length inputs.
- Buffers up to CMD_DEPTH queued SPI transactions in a command FIFO and issues them to spi_master one at a time.
- Captures spi_master rx_data when each transaction ends, masks it to the transaction length, and pushes it into a response FIFO for the host.
- Lets a host or CPU bus stream transactions without polling busy.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2
RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2
SLAVE_ADDRS_LEN, 3, width of slave address field; matches spi_master

Ports:
clk  in  1  system clock; the same clock that drives spi_master
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  host presents a command
cmd_ready  out  1  command FIFO can accept; high when cmd_count < CMD_DEPTH
cmd_data  in  32  transmit word, right-aligned
cmd_addr  in  SLAVE_ADDRS_LEN  target slave index
cmd_len  in  2  0=8, 1=16, 2=24, 3=32 bit
cmd_nores  in  1  discard response (write-only transaction)
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  host pops response
rsp_data  out  32  masked receive word at FIFO head
rsp_addr  out  SLAVE_ADDRS_LEN  slave index of the response at head
spi_start  out  1  to spi_master start_trans
spi_tx_data  out  32  to spi_master tx_data
spi_chip_addr  out  SLAVE_ADDRS_LEN  to spi_master chipADDRS
spi_length  out  2  to spi_master transaction_length
spi_busy  in  1  from spi_master busy
spi_rx_data  in  32  from spi_master rx_data
cmd_count  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy
idle  out  1  state is IDLE and command FIFO is empty

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty; state IDLE; spi_start=0; spi_tx_data, spi_chip_addr, spi_length = 0; rsp_valid=0; cmd_count=0; idle=1.
- Reset mid-transaction aborts the sequence and drops every queued command and response.
- Command push: on cmd_valid & cmd_ready at a clk edge. cmd_valid while cmd_ready=0 is ignored, with no overwrite. There is no bypass, so a push into a full FIFO is refused even in the cycle of a pop.
- Response pop: on rsp_valid & rsp_ready. rsp_data and rsp_addr are the FIFO head, stable while rsp_valid=1 and no pop occurs.
- Simultaneous push and pop on either FIFO is legal; occupancy stays unchanged. Pointers wrap modulo depth.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE.
  - IDLE -> ISSUE when the command FIFO is non-empty and (head.nores=1 or rsp_count + 0 < RSP_DEPTH). This reserves the response slot before issuing, so CAPTURE never stalls.
  - ISSUE: load spi_tx_data, spi_chip_addr and spi_length from the head (registered). Assert spi_start=1 for exactly this one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: spi_start=0; wait for spi_busy=1, then go to WAIT_DONE. If spi_busy does not rise within 4 cycles, re-enter ISSUE (restart); count retries without limit.
  - WAIT_DONE: wait for spi_busy=0, then go to CAPTURE. spi_master updates rx_data in the cycle before busy falls, so spi_rx_data is valid in CAPTURE.
  - CAPTURE: pop the command FIFO. If nores=0, push {masked rx, addr} into the response FIFO. Go to IDLE.
- spi_tx_data, spi_chip_addr and spi_length hold their values from ISSUE until the next ISSUE.
- Mask rule: len0 keeps rx[7:0], len1 keeps rx[15:0], len2 keeps rx[23:0], len3 keeps all 32 bits; upper bits are zero.
- Minimum per-transaction overhead outside spi_busy: 1 (IDLE) + 1 (ISSUE) + 1 (CAPTURE) cycles.
- Response reservation: rsp_count counts only stored entries, because at most one transaction is in flight. If the response FIFO is full and head.nores=0, the FSM waits in IDLE, and the command FIFO keeps accepting until it is full.
- idle must be low from the cycle after any accepted push until the final CAPTURE completes.

Test Plan:
- Single 8-bit: push data=0x000000A5, addr=2, len=0; slave model returns 0xFFFFFF3C on rx. Expect exactly one spi_start pulse, spi_chip_addr=2, rsp_data=0x0000003C, rsp_addr=2, idle=1 afterwards.
- Back-to-back: push 4 commands (len 3, data 0x11111111..0x44444444) with the host not popping. Expect cmd_ready=0 after the 4th push only, issue order preserved, and 4 responses in order. A 5th push accepted while full must be refused until a CAPTURE pops an entry.
- Response backpressure: RSP_DEPTH=4, rsp_ready=0, push 6 commands. Expect exactly 4 transactions issued; the FSM waits in IDLE with spi_start=0. Pop one response and expect the 5th transaction to issue.
- nores: push len=1 with cmd_nores=1 while the response FIFO is full. Expect it to issue, with no response pushed and rsp count unchanged.
- Busy timeout: hold spi_busy=0 after ISSUE. Expect spi_start re-pulsed every 5 cycles. Release busy and expect normal completion with a single response.
- Reset mid-WAIT_DONE with 2 commands queued: drive rst=0. Expect spi_start=0, cmd_count=0, rsp_valid=0 and idle=1 immediately (asynchronously), and no response after reset is released.
